// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: access encodings, FSM states,
// default RAM depth and the access legality rule.
package load_store_unit_pkg;

  localparam int DEPTH_DEFAULT = 256;

  // funct3 access size/sign encodings
  typedef enum logic [2:0] {
    F3_B  = 3'b000,
    F3_H  = 3'b001,
    F3_W  = 3'b010,
    F3_BU = 3'b100,
    F3_HU = 3'b101
  } funct3_e;

  typedef enum logic {
    IDLE   = 1'b0,
    RDWAIT = 1'b1
  } lsu_state_e;

  // An access is legal when its funct3 exists for that direction (stores have
  // no unsigned forms) and the address is naturally aligned for its size.
  function automatic logic access_legal(input logic       is_store,
                                        input logic [2:0] f3,
                                        input logic [1:0] off);
    logic ok;
    case (f3)
      F3_B:    ok = 1'b1;
      F3_H:    ok = ~off[0];
      F3_W:    ok = (off == 2'b00);
      F3_BU:   ok = ~is_store;
      F3_HU:   ok = ~is_store & ~off[0];
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/load_store_unit_dmem_ram.sv
// Data RAM: DEPTH 32-bit words, four byte-write enables, registered read.
// Contents are deliberately not reset.
module dmem_ram #(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  logic [3:0]    we,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  // Byte-lane writes plus a read port that holds its last value when idle;
  // a read in the same cycle as a write returns the old word.
  always_ff @(posedge clk) begin
    for (int lane = 0; lane < 4; lane++) begin
      if (we[lane]) begin
        mem[addr][lane*8 +: 8] <= wdata[lane*8 +: 8];
      end
    end
    if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: two-state load FSM, store byte-enable generation,
// load lane select/extension and access fault decode around dmem_ram.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [2:0]  funct3,
  input  logic [31:0] DataAdr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        Stall,
  output logic        AccessFault
);

  localparam int AW = $clog2(DEPTH);

  lsu_state_e    state_reg;
  logic [2:0]    ld_funct3_reg;
  logic [1:0]    ld_off_reg;
  logic [AW-1:0] word_addr;
  logic [3:0]    be;
  logic [31:0]   wdata_rep;
  logic [31:0]   ram_rdata;
  logic          legal;
  logic          in_idle;
  logic          do_store;
  logic          do_load;
  logic [7:0]    byte_sel;
  logic [15:0]   half_sel;
  logic          unused_adr_bits;

  // Upper address bits only wrap, so they are intentionally dropped.
  assign word_addr       = DataAdr[AW+1:2];
  assign unused_adr_bits = ^DataAdr[31:AW+2];

  // Accesses are only decoded in IDLE; RDWAIT belongs to the held load.
  assign in_idle     = (state_reg == IDLE);
  assign legal       = access_legal(MemWrite, funct3, DataAdr[1:0]);
  assign do_store    = in_idle & ~reset & MemWrite & legal;
  assign do_load     = in_idle & ~reset & MemRead & ~MemWrite & legal;
  assign AccessFault = in_idle & ~reset & (MemRead | MemWrite) & ~legal;
  assign Stall       = do_load;

  // Per-lane byte enable and replicated store data.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign be[gi] = (funct3 == F3_W) ? 1'b1 :
                    (funct3 == F3_H) ? (DataAdr[1] == 1'(gi / 2)) :
                                       (DataAdr[1:0] == 2'(gi));
    assign wdata_rep[gi*8 +: 8] = (funct3 == F3_W) ? WriteData[gi*8 +: 8] :
                                  (funct3 == F3_H) ? WriteData[(gi%2)*8 +: 8] :
                                                     WriteData[7:0];
  end

  dmem_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .re    (do_load),
    .addr  (word_addr),
    .we    (do_store ? be : 4'b0000),
    .wdata (wdata_rep),
    .rdata (ram_rdata)
  );

  // Load FSM: capture size/offset at issue, return to IDLE after one wait cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      ld_funct3_reg <= 3'b000;
      ld_off_reg    <= 2'b00;
    end else begin
      case (state_reg)
        IDLE: begin
          if (do_load) begin
            state_reg     <= RDWAIT;
            ld_funct3_reg <= funct3;
            ld_off_reg    <= DataAdr[1:0];
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign byte_sel = ram_rdata[{ld_off_reg, 3'b000} +: 8];
  assign half_sel = ld_off_reg[1] ? ram_rdata[31:16] : ram_rdata[15:0];

  // Load result: lane select and sign/zero extension, zero outside RDWAIT.
  always_comb begin
    ReadData = 32'h0;
    if (state_reg == RDWAIT) begin
      case (ld_funct3_reg)
        F3_B:    ReadData = {{24{byte_sel[7]}}, byte_sel};
        F3_BU:   ReadData = {24'h0, byte_sel};
        F3_H:    ReadData = {{16{half_sel[15]}}, half_sel};
        F3_HU:   ReadData = {16'h0, half_sel};
        F3_W:    ReadData = ram_rdata;
        default: ReadData = 32'h0;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: stimulus pushes per-cycle expected
// outputs from a byte-array memory model; a negedge monitor pops and compares.
module tb_load_store_unit;

  localparam int DEPTH  = 16;
  localparam int NBYTES = DEPTH * 4;

  logic        clk;
  logic        reset;
  logic        MemRead;
  logic        MemWrite;
  logic [2:0]  funct3;
  logic [31:0] DataAdr;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        Stall;
  logic        AccessFault;

  load_store_unit #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .funct3      (funct3),
    .DataAdr     (DataAdr),
    .WriteData   (WriteData),
    .ReadData    (ReadData),
    .Stall       (Stall),
    .AccessFault (AccessFault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          chk;
    logic        stall;
    logic        fault;
    logic [31:0] rd;
    string       tag;
  } exp_t;

  exp_t       q[$];
  int         total  = 0;
  int         passed = 0;
  logic [7:0] mbytes [NBYTES];

  // Monitor: one expected entry per cycle, compared mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      if (e.chk) begin
        total++;
        if (Stall === e.stall && AccessFault === e.fault && ReadData === e.rd) begin
          passed++;
          $display("ok   %s: stall=%0b fault=%0b rdata=%08h", e.tag, Stall, AccessFault, ReadData);
        end else begin
          $display("FAIL %s: got stall=%0b fault=%0b rdata=%08h, expected stall=%0b fault=%0b rdata=%08h",
                   e.tag, Stall, AccessFault, ReadData, e.stall, e.fault, e.rd);
        end
      end
    end
  end

  function automatic int size_of(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic bit legal_m(input bit wr, input logic [2:0] f3, input logic [31:0] a);
    bit code_ok;
    if (wr) code_ok = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2);
    else    code_ok = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    return code_ok && ((a % size_of(f3)) == 0);
  endfunction

  function automatic logic [31:0] load_m(input logic [2:0] f3, input logic [31:0] a);
    logic [31:0] v;
    int          sz;
    sz = size_of(f3);
    v  = 0;
    for (int i = 0; i < sz; i++) v = v | (32'(mbytes[(a + i) % NBYTES]) << (8 * i));
    if (f3[2] == 1'b0 && sz == 1 && v[7])  v = v | 32'hFFFFFF00;
    if (f3[2] == 1'b0 && sz == 2 && v[15]) v = v | 32'hFFFF0000;
    return v;
  endfunction

  task automatic store_m(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    for (int i = 0; i < size_of(f3); i++) mbytes[(a + i) % NBYTES] = d[8*i +: 8];
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input bit chk, input logic st, input logic flt,
                      input logic [31:0] rd, input string tag);
    exp_t e;
    e.chk = chk; e.stall = st; e.fault = flt; e.rd = rd; e.tag = tag;
    q.push_back(e);
  endtask

  // One core instruction; loads hold inputs through RDWAIT like a stalled core.
  task automatic op(input bit rd, input bit wr, input logic [2:0] f3,
                    input logic [31:0] a, input logic [31:0] wd, input string tag);
    MemRead = rd; MemWrite = wr; funct3 = f3; DataAdr = a; WriteData = wd;
    if (!rd && !wr) begin
      push(1, 0, 0, 32'h0, {tag, " idle"});
      step();
    end else if (!legal_m(wr, f3, a)) begin
      push(1, 0, 1, 32'h0, {tag, " fault"});
      step();
    end else if (wr) begin
      push(1, 0, 0, 32'h0, {tag, " store"});
      store_m(f3, a, wd);
      step();
    end else begin
      push(1, 1, 0, 32'h0, {tag, " load issue"});
      step();
      push(1, 0, 0, load_m(f3, a), {tag, " load data"});
      step();
    end
    MemRead = 0; MemWrite = 0;
  endtask

  initial begin
    int          wait_cycles;
    bit          r, w;
    logic [2:0]  f3;
    logic [31:0] a;

    reset = 1; MemRead = 0; MemWrite = 0; funct3 = 0; DataAdr = 0; WriteData = 0;
    step();
    push(1, 0, 0, 32'h0, "reset state");
    step();
    reset = 0;

    // Fill the whole RAM so every later load has a known value.
    for (int i = 0; i < DEPTH; i++) op(0, 1, 3'd2, 32'(i * 4), $urandom, "init sw");

    op(0, 1, 3'd2, 32'h10, 32'hDEADBEEF, "sw deadbeef");
    op(1, 0, 3'd2, 32'h10, 32'h0, "lw 0x10");
    op(1, 0, 3'd0, 32'h13, 32'h0, "lb 0x13");
    op(1, 0, 3'd4, 32'h13, 32'h0, "lbu 0x13");
    op(1, 0, 3'd1, 32'h12, 32'h0, "lh 0x12");
    op(1, 0, 3'd5, 32'h10, 32'h0, "lhu 0x10");
    op(0, 1, 3'd0, 32'h11, 32'h123, "sb 0x11");
    op(1, 0, 3'd2, 32'h10, 32'h0, "lw after sb");
    op(1, 0, 3'd2, 32'h12, 32'h0, "lw misaligned");
    op(0, 1, 3'd1, 32'h11, 32'hFFFF, "sh misaligned");
    op(0, 1, 3'd4, 32'h10, 32'hFFFF, "sbu illegal");
    op(1, 0, 3'd3, 32'h10, 32'h0, "ld illegal");
    op(1, 0, 3'd2, 32'h10, 32'h0, "lw unchanged");
    op(1, 1, 3'd1, 32'h16, 32'hA5A5, "rd+wr as sh");
    op(1, 0, 3'd2, 32'h14, 32'h0, "lw after sh");

    // Reset during RDWAIT abandons the load; a store under reset is dropped.
    MemRead = 1; funct3 = 3'd2; DataAdr = 32'h20;
    push(1, 1, 0, 32'h0, "lw before reset issue");
    step();
    reset = 1; MemRead = 0; MemWrite = 1; WriteData = 32'h11111111;
    push(0, 0, 0, 32'h0, "reset in rdwait");
    step();
    push(1, 0, 0, 32'h0, "sw under reset");
    step();
    reset = 0; MemWrite = 0;
    push(1, 0, 0, 32'h0, "after reset");
    step();
    op(1, 0, 3'd2, 32'h20, 32'h0, "lw after reset");

    op(0, 1, 3'd2, 32'h0, 32'h55, "sw 0x55 @0");
    op(1, 0, 3'd2, 32'(NBYTES), 32'h0, "lw wrap");
    op(1, 0, 3'd0, 32'hFFFFFFC0, 32'h0, "lb wrap high");
    op(0, 0, 3'd0, 32'h0, 32'h0, "nop");

    for (int n = 0; n < 300; n++) begin
      r  = 1'($urandom);
      w  = 1'($urandom);
      f3 = 3'($urandom);
      a  = $urandom;
      if ($urandom_range(0, 3) != 0) a = a & ~32'(size_of(f3) - 1);
      op(r, w, f3, a, $urandom, "rand");
    end

    wait_cycles = 0;
    while (q.size() > 0 && wait_cycles < 20) begin
      step();
      wait_cycles++;
    end
    if (q.size() > 0) begin
      total++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
